// File: rtl/pu_fifo_pkg.sv
// Shared nitta attribute definitions: attribute bus layout and flag positions.
package pu_fifo_pkg;

    // Attribute bus width and flag bit positions used across processing units
    localparam int unsigned NittaAttrWidth   = 4;
    localparam int unsigned NittaSignIdx     = 0;
    localparam int unsigned NittaOverflowIdx = 1;

endpackage

// File: rtl/pu_fifo_mem.sv
// Register-array storage for pu_fifo: one synchronous write port, one asynchronous read port.
module pu_fifo_mem #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 36,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pu_fifo.sv
// FIFO processing unit: stores {attr, data} words pushed from the bus and drives the head
// onto a registered, OR-combinable output one cycle after signal_oe.
module pu_fifo
    import pu_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = NittaAttrWidth,
    parameter int unsigned SIGN       = NittaSignIdx,
    parameter int unsigned OVERFLOW   = NittaOverflowIdx,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    input  logic                  signal_rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned EntryW = ATTR_WIDTH + DATA_WIDTH;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         count_q, count_d;
    logic                  lost_q, lost_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;

    logic                  push, pop, mem_we;
    logic [EntryW-1:0]     head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ATTR_WIDTH-1:0] head_attr;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign pop       = signal_oe & signal_rd & ~empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign push      = signal_wr & (~full | pop);
    assign mem_we    = push & ~rst;
    assign head_data = head[DATA_WIDTH-1:0];
    assign head_attr = head[EntryW-1 -: ATTR_WIDTH];

    pu_fifo_mem #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({attr_in, data_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Next-state for pointers, occupancy, lost flag and the registered output bus
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lost_d     = lost_q;
        data_out_d = '0;
        attr_out_d = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (signal_oe) begin
            if (!empty) begin
                // Report any dropped write with this read, then forget it
                data_out_d           = head_data;
                attr_out_d           = head_attr;
                attr_out_d[SIGN]     = head_attr[SIGN];
                attr_out_d[OVERFLOW] = head_attr[OVERFLOW] | lost_q;
                lost_d               = 1'b0;
            end else begin
                // Underflow: zero word flagged as an error
                attr_out_d[OVERFLOW] = 1'b1;
            end
        end

        // A drop in the same cycle as a reporting read is kept for the next read
        if (signal_wr && !push) begin
            lost_d = 1'b1;
        end
    end

    // State register with synchronous, active-high reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lost_q     <= 1'b0;
            data_out_q <= '0;
            attr_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lost_q     <= lost_d;
            data_out_q <= data_out_d;
            attr_out_q <= attr_out_d;
        end
    end

    assign data_out = data_out_q;
    assign attr_out = attr_out_q;

endmodule

// File: tb/tb_pu_fifo.sv
// Scoreboard bench for pu_fifo: a queue-based reference model predicts each cycle's outputs.
module tb_pu_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 8;
    localparam int SIGN  = 0;
    localparam int OVF   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          signal_wr = 1'b0;
    logic          signal_oe = 1'b0;
    logic          signal_rd = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] attr_in = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] attr_out;
    logic          full;
    logic          empty;

    pu_fifo #(
        .DATA_WIDTH (DW),
        .ATTR_WIDTH (AW),
        .SIGN       (SIGN),
        .OVERFLOW   (OVF),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .signal_wr (signal_wr),
        .data_in   (data_in),
        .attr_in   (attr_in),
        .signal_oe (signal_oe),
        .signal_rd (signal_rd),
        .data_out  (data_out),
        .attr_out  (attr_out),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] attr;
        logic          full;
        logic          empty;
    } exp_t;

    exp_t              sb[$];
    logic [AW+DW-1:0]  m_q[$];
    logic              m_lost = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle and predict what the outputs must show after the next rising edge
    task automatic step(input logic rs, input logic wr, input logic [DW-1:0] d,
                        input logic [AW-1:0] a, input logic oe, input logic rd);
        exp_t e;
        logic fl, em, pop, push;
        @(negedge clk);
        rst = rs; signal_wr = wr; data_in = d; attr_in = a; signal_oe = oe; signal_rd = rd;
        e = '0;
        if (rs) begin
            m_q.delete();
            m_lost = 1'b0;
        end else begin
            fl = (m_q.size() == DEPTH);
            em = (m_q.size() == 0);
            if (oe && !em) begin
                e.data      = m_q[0][DW-1:0];
                e.attr      = m_q[0][AW+DW-1:DW];
                e.attr[OVF] = e.attr[OVF] | m_lost;
                m_lost      = 1'b0;
            end else if (oe) begin
                e.attr[OVF] = 1'b1;
            end
            pop  = oe && rd && !em;
            push = wr && (!fl || pop);
            if (wr && !push) m_lost = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({a, d});
        end
        e.full  = (m_q.size() == DEPTH);
        e.empty = (m_q.size() == 0);
        sb.push_back(e);
    endtask

    task automatic push_w(input logic [DW-1:0] d, input logic [AW-1:0] a);
        step(1'b0, 1'b1, d, a, 1'b0, 1'b0);
    endtask

    task automatic pop_w();
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output cycle against the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data_out", 64'(data_out), 64'(e.data));
                check("attr_out", 64'(attr_out), 64'(e.attr));
                check("full", 64'(full), 64'(e.full));
                check("empty", 64'(empty), 64'(e.empty));
            end
        end
    end

    initial begin : driver
        do_rst();
        do_rst();

        // Ordered read-out of three words
        push_w(32'd5, 4'h0);
        push_w(32'd7, 4'h0);
        push_w(32'd9, 4'h0);
        repeat (3) pop_w();
        idle();

        // Overfill: ninth write dropped, first read carries the error flag
        for (int i = 0; i < 9; i++) push_w(32'h100 + 32'(i), 4'h0);
        for (int i = 0; i < 8; i++) pop_w();
        idle();

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) push_w(32'h200 + 32'(i), 4'h8);
        step(1'b0, 1'b1, 32'hAA, 4'h0, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 8; i++) pop_w();
        idle();

        // Underflow, then confirm pointers were untouched
        pop_w();
        push_w(32'h31, 4'h4);
        pop_w();
        idle();

        // Output enable without read keeps the entry
        push_w(32'hFFFF_FFFD, 4'h1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        pop_w();
        idle();

        // Reset mid-stream discards contents and a concurrent push/read
        push_w(32'h41, 4'h0);
        push_w(32'h42, 4'h0);
        step(1'b1, 1'b1, 32'h43, 4'h0, 1'b1, 1'b1);
        push_w(32'h1234, 4'h2);
        pop_w();
        idle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), DW'($urandom),
                 AW'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));
        end
        idle();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
